// File: rtl/gbuf_pkg.sv
// Shared types and default geometry for the TPU global buffer.
// Bank-select encodings, clear-sequencer states and word-width derivation.
package gbuf_pkg;

    localparam int unsigned GBUF_ADDR_WIDTH = 12;
    localparam int unsigned GBUF_DEPTH      = 4096;
    localparam int unsigned GBUF_ELEM_WIDTH = 16;
    localparam int unsigned GBUF_LANES      = 10;

    function automatic int unsigned word_width(input int unsigned elem_w, input int unsigned lanes);
        return elem_w * lanes;
    endfunction

    localparam int unsigned GBUF_WORD_WIDTH = word_width(GBUF_ELEM_WIDTH, GBUF_LANES);

    typedef enum logic [1:0] {
        SEL_A    = 2'd0,
        SEL_B    = 2'd1,
        SEL_P    = 2'd2,
        SEL_RSVD = 2'd3
    } gbuf_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } gbuf_state_e;

endpackage

// File: rtl/gbuf_bank.sv
// Single-port RAM bank with lane write mask, address range check and a 1..2 cycle read pipe.
// Read results are steered into separate TPU and host holding registers by a request tag.
module gbuf_bank
    import gbuf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = GBUF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = GBUF_DEPTH,
    parameter int unsigned ELEM_WIDTH = GBUF_ELEM_WIDTH,
    parameter int unsigned LANES      = GBUF_LANES,
    parameter int unsigned WORD_WIDTH = word_width(ELEM_WIDTH, LANES),
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    input  logic [LANES-1:0]      wmask_i,
    input  logic                  host_i,
    output logic                  oob_o,
    output logic [WORD_WIDTH-1:0] tpu_rdata_o,
    output logic [WORD_WIDTH-1:0] host_rdata_o,
    output logic                  host_rvalid_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    logic                  in_range;
    logic                  rd;
    logic [IDX_W-1:0]      idx;
    logic [WORD_WIDTH-1:0] rd_word;

    assign in_range = 32'(addr_i) < DEPTH;
    assign idx      = addr_i[IDX_W-1:0];
    assign rd       = en_i & ~we_i;
    assign oob_o    = en_i & ~in_range;
    assign rd_word  = in_range ? mem[idx] : '0;

    always_ff @(posedge clk_i) begin
        if (en_i && we_i && in_range) begin
            for (int l = 0; l < int'(LANES); l++) begin
                if (wmask_i[l]) begin
                    mem[idx][l*ELEM_WIDTH +: ELEM_WIDTH] <= wdata_i[l*ELEM_WIDTH +: ELEM_WIDTH];
                end
            end
        end
    end

    // Final-stage inputs: straight from the array, or via one extra pipe stage.
    logic                  f_vld;
    logic                  f_tag;
    logic [WORD_WIDTH-1:0] f_dat;

    if (RD_LATENCY >= 2) begin : g_pipe
        logic                  p_vld_q;
        logic                  p_tag_q;
        logic [WORD_WIDTH-1:0] p_dat_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                p_vld_q <= 1'b0;
                p_tag_q <= 1'b0;
            end else begin
                p_vld_q <= rd;
                p_tag_q <= host_i;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rd) begin
                p_dat_q <= rd_word;
            end
        end

        assign f_vld = p_vld_q;
        assign f_tag = p_tag_q;
        assign f_dat = p_dat_q;
    end else begin : g_direct
        assign f_vld = rd;
        assign f_tag = host_i;
        assign f_dat = rd_word;
    end

    logic [WORD_WIDTH-1:0] tpu_rdata_q;
    logic [WORD_WIDTH-1:0] host_rdata_q;
    logic                  host_rvalid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tpu_rdata_q   <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            host_rvalid_q <= f_vld & f_tag;
            if (f_vld && !f_tag) begin
                tpu_rdata_q <= f_dat;
            end
            if (f_vld && f_tag) begin
                host_rdata_q <= f_dat;
            end
        end
    end

    assign tpu_rdata_o   = tpu_rdata_q;
    assign host_rdata_o  = host_rdata_q;
    assign host_rvalid_o = host_rvalid_q;

endmodule

// File: rtl/tpu_gbuf_bank3.sv
// TPU global buffer: banks A, B, P shared between the TPU and a host port,
// with a P-bank clear sequencer and a sticky error flag.
module tpu_gbuf_bank3
    import gbuf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = GBUF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = GBUF_DEPTH,
    parameter int unsigned ELEM_WIDTH = GBUF_ELEM_WIDTH,
    parameter int unsigned LANES      = GBUF_LANES,
    parameter int unsigned WORD_WIDTH = word_width(ELEM_WIDTH, LANES),
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  tpu_busy_i,
    input  logic                  ena_i,
    input  logic                  wea_i,
    input  logic [ADDR_WIDTH-1:0] addra_i,
    output logic [WORD_WIDTH-1:0] worda_o,
    input  logic                  enb_i,
    input  logic                  web_i,
    input  logic [ADDR_WIDTH-1:0] addrb_i,
    output logic [WORD_WIDTH-1:0] wordb_o,
    input  logic                  enp_i,
    input  logic                  wep_i,
    input  logic [ADDR_WIDTH-1:0] addrp_i,
    input  logic [WORD_WIDTH-1:0] wordp_i,
    output logic [WORD_WIDTH-1:0] wordp_o,
    input  logic                  host_req_i,
    input  logic                  host_we_i,
    input  logic [1:0]            host_sel_i,
    input  logic [ADDR_WIDTH-1:0] host_addr_i,
    input  logic [WORD_WIDTH-1:0] host_wdata_i,
    input  logic [LANES-1:0]      host_wmask_i,
    output logic                  host_gnt_o,
    output logic                  host_rvalid_o,
    output logic [WORD_WIDTH-1:0] host_rdata_o,
    input  logic                  clear_i,
    output logic                  clear_done_o,
    output logic                  err_o,
    input  logic                  err_clr_i
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    gbuf_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  err_q, err_d;

    // Arbitration: the TPU always wins; the host waits for a free bank.
    gbuf_sel_e sel;
    logic      tpu_en_sel;
    logic      host_a, host_b, host_p, tpu_p;

    assign sel = gbuf_sel_e'(host_sel_i);

    always_comb begin
        tpu_en_sel = 1'b1;
        unique case (sel)
            SEL_A:   tpu_en_sel = ena_i;
            SEL_B:   tpu_en_sel = enb_i;
            SEL_P:   tpu_en_sel = enp_i;
            default: tpu_en_sel = 1'b1;
        endcase
    end

    assign host_gnt_o = host_req_i & ~tpu_busy_i & (sel != SEL_RSVD) & ~tpu_en_sel
                      & ~((sel == SEL_P) & (state_q != IDLE));
    assign host_a = host_gnt_o & (sel == SEL_A);
    assign host_b = host_gnt_o & (sel == SEL_B);
    assign host_p = host_gnt_o & (sel == SEL_P);
    assign tpu_p  = enp_i & (state_q == IDLE);

    // The TPU has one write bus; A/B writes reuse wordp_i.
    logic                  a_en, a_we, b_en, b_we;
    logic [ADDR_WIDTH-1:0] a_addr, b_addr;
    logic [WORD_WIDTH-1:0] a_wdata, b_wdata;
    logic [LANES-1:0]      a_mask, b_mask;

    assign a_en    = ena_i | host_a;
    assign a_we    = ena_i ? wea_i : host_we_i;
    assign a_addr  = ena_i ? addra_i : host_addr_i;
    assign a_wdata = ena_i ? wordp_i : host_wdata_i;
    assign a_mask  = ena_i ? '1 : host_wmask_i;
    assign b_en    = enb_i | host_b;
    assign b_we    = enb_i ? web_i : host_we_i;
    assign b_addr  = enb_i ? addrb_i : host_addr_i;
    assign b_wdata = enb_i ? wordp_i : host_wdata_i;
    assign b_mask  = enb_i ? '1 : host_wmask_i;

    logic                  p_en, p_we, p_tag;
    logic [ADDR_WIDTH-1:0] p_addr;
    logic [WORD_WIDTH-1:0] p_wdata;
    logic [LANES-1:0]      p_mask;

    always_comb begin
        p_en    = 1'b0;
        p_we    = host_we_i;
        p_addr  = host_addr_i;
        p_wdata = host_wdata_i;
        p_mask  = host_wmask_i;
        p_tag   = 1'b1;
        if (state_q == CLEAR) begin
            p_en    = 1'b1;
            p_we    = 1'b1;
            p_addr  = cnt_q;
            p_wdata = '0;
            p_mask  = '1;
            p_tag   = 1'b0;
        end else if (tpu_p) begin
            p_en    = 1'b1;
            p_we    = wep_i;
            p_addr  = addrp_i;
            p_wdata = wordp_i;
            p_mask  = '1;
            p_tag   = 1'b0;
        end else if (host_p) begin
            p_en    = 1'b1;
        end
    end

    logic                  oob_a, oob_b, oob_p;
    logic                  rv_a, rv_b, rv_p;
    logic [WORD_WIDTH-1:0] hd_a, hd_b, hd_p;

    gbuf_bank #(
        .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .ELEM_WIDTH(ELEM_WIDTH),
        .LANES(LANES), .WORD_WIDTH(WORD_WIDTH), .RD_LATENCY(RD_LATENCY)
    ) u_bank_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(a_en), .we_i(a_we), .addr_i(a_addr),
        .wdata_i(a_wdata), .wmask_i(a_mask), .host_i(~ena_i), .oob_o(oob_a),
        .tpu_rdata_o(worda_o), .host_rdata_o(hd_a), .host_rvalid_o(rv_a)
    );

    gbuf_bank #(
        .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .ELEM_WIDTH(ELEM_WIDTH),
        .LANES(LANES), .WORD_WIDTH(WORD_WIDTH), .RD_LATENCY(RD_LATENCY)
    ) u_bank_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(b_en), .we_i(b_we), .addr_i(b_addr),
        .wdata_i(b_wdata), .wmask_i(b_mask), .host_i(~enb_i), .oob_o(oob_b),
        .tpu_rdata_o(wordb_o), .host_rdata_o(hd_b), .host_rvalid_o(rv_b)
    );

    gbuf_bank #(
        .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .ELEM_WIDTH(ELEM_WIDTH),
        .LANES(LANES), .WORD_WIDTH(WORD_WIDTH), .RD_LATENCY(RD_LATENCY)
    ) u_bank_p (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(p_en), .we_i(p_we), .addr_i(p_addr),
        .wdata_i(p_wdata), .wmask_i(p_mask), .host_i(p_tag), .oob_o(oob_p),
        .tpu_rdata_o(wordp_o), .host_rdata_o(hd_p), .host_rvalid_o(rv_p)
    );

    // Host read data follows the bank that last answered the host.
    gbuf_sel_e last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= SEL_A;
        end else if (rv_a) begin
            last_q <= SEL_A;
        end else if (rv_b) begin
            last_q <= SEL_B;
        end else if (rv_p) begin
            last_q <= SEL_P;
        end
    end

    assign host_rvalid_o = rv_a | rv_b | rv_p;

    always_comb begin
        host_rdata_o = hd_a;
        if (rv_a)                       host_rdata_o = hd_a;
        else if (rv_b)                  host_rdata_o = hd_b;
        else if (rv_p)                  host_rdata_o = hd_p;
        else if (last_q == SEL_B)       host_rdata_o = hd_b;
        else if (last_q == SEL_P)       host_rdata_o = hd_p;
    end

    // Clear sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clear_done_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear_i && !tpu_busy_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                clear_done_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign err_d = oob_a | oob_b | oob_p | (enp_i & (state_q != IDLE)) | (err_q & ~err_clr_i);
    assign err_o = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_tpu_gbuf_bank3.sv
// Directed bench for tpu_gbuf_bank3: two instances (read latency 1 and 2, DEPTH 16)
// share all stimulus; expected values are hand-built from the access patterns.
module tb_tpu_gbuf_bank3;

    localparam int AW    = 12;
    localparam int DEPTH = 16;
    localparam int LN    = 10;
    localparam int WW    = 160;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          tpu_busy_i;
    logic          ena_i, wea_i, enb_i, web_i, enp_i, wep_i;
    logic [AW-1:0] addra_i, addrb_i, addrp_i;
    logic [WW-1:0] wordp_i;
    logic          host_req_i, host_we_i;
    logic [1:0]    host_sel_i;
    logic [AW-1:0] host_addr_i;
    logic [WW-1:0] host_wdata_i;
    logic [LN-1:0] host_wmask_i;
    logic          clear_i, err_clr_i;

    logic [WW-1:0] worda_o, wordb_o, wordp_o, host_rdata_o;
    logic          host_gnt_o, host_rvalid_o, clear_done_o, err_o;
    logic [WW-1:0] worda2, wordb2, wordp2, host_rdata2;
    logic          host_gnt2, host_rvalid2, clear_done2, err2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    tpu_gbuf_bank3 #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(1)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .tpu_busy_i(tpu_busy_i),
        .ena_i(ena_i), .wea_i(wea_i), .addra_i(addra_i), .worda_o(worda_o),
        .enb_i(enb_i), .web_i(web_i), .addrb_i(addrb_i), .wordb_o(wordb_o),
        .enp_i(enp_i), .wep_i(wep_i), .addrp_i(addrp_i), .wordp_i(wordp_i), .wordp_o(wordp_o),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_sel_i(host_sel_i),
        .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i), .host_wmask_i(host_wmask_i),
        .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
        .clear_i(clear_i), .clear_done_o(clear_done_o), .err_o(err_o), .err_clr_i(err_clr_i)
    );

    tpu_gbuf_bank3 #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(2)) u_dut_lat2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .tpu_busy_i(tpu_busy_i),
        .ena_i(ena_i), .wea_i(wea_i), .addra_i(addra_i), .worda_o(worda2),
        .enb_i(enb_i), .web_i(web_i), .addrb_i(addrb_i), .wordb_o(wordb2),
        .enp_i(enp_i), .wep_i(wep_i), .addrp_i(addrp_i), .wordp_i(wordp_i), .wordp_o(wordp2),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_sel_i(host_sel_i),
        .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i), .host_wmask_i(host_wmask_i),
        .host_gnt_o(host_gnt2), .host_rvalid_o(host_rvalid2), .host_rdata_o(host_rdata2),
        .clear_i(clear_i), .clear_done_o(clear_done2), .err_o(err2), .err_clr_i(err_clr_i)
    );

    task automatic check_eq(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [WW-1:0] row_a(input int i);
        logic [WW-1:0] w;
        for (int j = 0; j < LN; j++) w[j*16 +: 16] = 16'((i + 1) * (j + 1));
        return w;
    endfunction

    function automatic logic [WW-1:0] row_b(input int i);
        logic [WW-1:0] w;
        w = '0;
        w[i*16 +: 16] = 16'd2;
        return w;
    endfunction

    function automatic logic [WW-1:0] exp_p(input int i);
        logic [WW-1:0] w;
        for (int j = 0; j < LN; j++) w[j*16 +: 16] = 16'(2 * (i + 1) * (j + 1));
        return w;
    endfunction

    task automatic host_write(input logic [1:0] sel, input int addr, input logic [WW-1:0] data,
                              input logic [LN-1:0] mask);
        bit got = 0;
        host_req_i = 1'b1; host_we_i = 1'b1; host_sel_i = sel;
        host_addr_i = AW'(addr); host_wdata_i = data; host_wmask_i = mask;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk_i);
            if (host_gnt_o) got = 1;
        end
        if (got) tick();
        else check_eq("host_wr_gnt_timeout", 0, 1);
        host_req_i = 1'b0; host_we_i = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] sel, input int addr, output logic [WW-1:0] data);
        bit got = 0;
        bit vld = 0;
        data = '0;
        host_req_i = 1'b1; host_we_i = 1'b0; host_sel_i = sel; host_addr_i = AW'(addr);
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk_i);
            if (host_gnt_o) got = 1;
        end
        if (got) tick();
        host_req_i = 1'b0;
        if (!got) begin
            check_eq("host_rd_gnt_timeout", 0, 1);
        end else begin
            for (int c = 0; c < 8 && !vld; c++) begin
                if (host_rvalid_o) begin
                    vld = 1;
                    data = host_rdata_o;
                end else begin
                    tick();
                end
            end
            if (!vld) check_eq("host_rvalid_timeout", 0, 1);
        end
    endtask

    task automatic pulse_err_clr();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
    endtask

    logic [WW-1:0] pat1, d, a_w, p_w, exp4, pat6;
    logic [WW-1:0] b_rows [LN];
    int            done_n, done_cnt, ever;
    int unsigned   acc;

    initial begin
        rst_ni = 1'b0; tpu_busy_i = 0;
        ena_i = 0; wea_i = 0; enb_i = 0; web_i = 0; enp_i = 0; wep_i = 0;
        addra_i = '0; addrb_i = '0; addrp_i = '0; wordp_i = '0;
        host_req_i = 0; host_we_i = 0; host_sel_i = '0; host_addr_i = '0;
        host_wdata_i = '0; host_wmask_i = '0; clear_i = 0; err_clr_i = 0;
        pat1 = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888, 32'h9999_AAAA};
        pat6 = {32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1234_5678, 32'hCAFE_BABE, 32'h5A5A_A5A5};

        repeat (3) tick();
        check_eq("rst_worda", worda_o, '0);
        check_eq("rst_wordp", wordp_o, '0);
        check_eq("rst_host_rdata", host_rdata_o, '0);
        check_eq("rst_rvalid", WW'(host_rvalid_o), 0);
        check_eq("rst_clear_done", WW'(clear_done_o), 0);
        check_eq("rst_err", WW'(err_o), 0);
        rst_ni = 1'b1;
        tick();

        // TPU read of A[5] at both latencies
        host_write(2'd0, 5, pat1, '1);
        ena_i = 1; addra_i = AW'(5);
        tick();
        ena_i = 0;
        check_eq("lat1_worda_n1", worda_o, pat1);
        check_eq("lat2_worda_n1", worda2, '0);
        tick();
        check_eq("lat2_worda_n2", worda2, pat1);
        check_eq("lat1_worda_hold", worda_o, pat1);

        // Load A and B, emulate the TPU computing P = A*B, read P back
        for (int i = 0; i < LN; i++) host_write(2'd0, i, row_a(i), '1);
        for (int i = 0; i < LN; i++) host_write(2'd1, i, row_b(i), '1);
        tpu_busy_i = 1;
        for (int k = 0; k < LN; k++) begin
            enb_i = 1; addrb_i = AW'(k);
            tick();
            enb_i = 0;
            b_rows[k] = wordb_o;
        end
        for (int i = 0; i < LN; i++) begin
            ena_i = 1; addra_i = AW'(i);
            tick();
            ena_i = 0;
            a_w = worda_o;
            for (int j = 0; j < LN; j++) begin
                acc = 0;
                for (int k = 0; k < LN; k++) acc += a_w[k*16 +: 16] * b_rows[k][j*16 +: 16];
                p_w[j*16 +: 16] = 16'(acc);
            end
            enp_i = 1; wep_i = 1; addrp_i = AW'(i); wordp_i = p_w;
            tick();
            enp_i = 0; wep_i = 0;
        end
        tpu_busy_i = 0;
        for (int i = 0; i < LN; i++) begin
            host_read(2'd2, i, d);
            check_eq($sformatf("p_row%0d", i), d, exp_p(i));
        end

        // Conflict with the TPU on bank A, then tpu_busy and reserved select
        ena_i = 1; addra_i = '0;
        host_req_i = 1; host_we_i = 0; host_sel_i = 2'd0; host_addr_i = AW'(5);
        @(negedge clk_i);
        check_eq("conflict_gnt", WW'(host_gnt_o), 0);
        tick();
        ena_i = 0;
        @(negedge clk_i);
        check_eq("gnt_after_release", WW'(host_gnt_o), 1);
        tick();
        host_req_i = 0;
        check_eq("conflict_rvalid", WW'(host_rvalid_o), 1);
        check_eq("conflict_rdata", host_rdata_o, row_a(5));
        tpu_busy_i = 1;
        host_req_i = 1; host_sel_i = 2'd1;
        ever = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            if (host_gnt_o) ever++;
            tick();
        end
        check_eq("busy_never_gnt", WW'(ever), 0);
        tpu_busy_i = 0;
        host_sel_i = 2'd3;
        @(negedge clk_i);
        check_eq("rsvd_sel_gnt", WW'(host_gnt_o), 0);
        tick();
        host_req_i = 0;

        // Lane-masked host write
        host_write(2'd2, 3, '1, '1);
        host_write(2'd2, 3, '0, 10'b0000000101);
        host_read(2'd2, 3, d);
        exp4 = '1;
        exp4[15:0]  = 16'h0;
        exp4[47:32] = 16'h0;
        check_eq("masked_write", d, exp4);

        // Clear of bank P with a TPU P access and a host P request mid-clear
        check_eq("err_pre_clear", WW'(err_o), 0);
        clear_i = 1;
        done_n = 0; done_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) clear_i = 0;
            if (n == 3) begin enp_i = 1; wep_i = 0; addrp_i = '0; end
            if (n == 4) enp_i = 0;
            if (n == 5) begin host_req_i = 1; host_we_i = 0; host_sel_i = 2'd2; host_addr_i = '0; end
            if (n == 6) begin
                check_eq("clear_host_p_gnt", WW'(host_gnt_o), 0);
                host_req_i = 0;
            end
            if (clear_done_o) begin done_cnt++; done_n = n; end
        end
        check_eq("clear_done_cycle", WW'(done_n), 17);
        check_eq("clear_done_width", WW'(done_cnt), 1);
        check_eq("clear_tpu_p_err", WW'(err_o), 1);
        pulse_err_clr();
        check_eq("err_cleared", WW'(err_o), 0);
        for (int i = 0; i < DEPTH; i++) begin
            host_read(2'd2, i, d);
            check_eq($sformatf("p_clear_row%0d", i), d, '0);
        end

        // Out-of-range addresses
        host_write(2'd0, DEPTH, '1, '1);
        check_eq("oob_wr_err", WW'(err_o), 1);
        pulse_err_clr();
        host_read(2'd0, DEPTH, d);
        check_eq("oob_rd_data", d, '0);
        check_eq("oob_rd_err", WW'(err_o), 1);
        host_read(2'd0, 0, d);
        check_eq("oob_no_alias", d, row_a(0));
        ena_i = 1; addra_i = AW'(DEPTH);
        tick();
        ena_i = 0;
        check_eq("oob_tpu_rd", worda_o, '0);
        pulse_err_clr();

        // Async reset in the middle of a clear
        host_write(2'd2, 10, pat6, '1);
        host_write(2'd2, 0, pat6, '1);
        clear_i = 1;
        done_cnt = 0;
        for (int n = 1; n <= 5; n++) begin
            tick();
            if (n == 1) clear_i = 0;
            if (clear_done_o) done_cnt++;
        end
        rst_ni = 0;
        #1;
        check_eq("rst_mid_worda", worda_o, '0);
        check_eq("rst_mid_err", WW'(err_o), 0);
        tick();
        tick();
        rst_ni = 1;
        for (int n = 0; n < 25; n++) begin
            tick();
            if (clear_done_o) done_cnt++;
        end
        check_eq("rst_mid_no_done", WW'(done_cnt), 0);
        check_eq("rst_mid_no_rvalid", WW'(host_rvalid_o), 0);
        host_read(2'd2, 10, d);
        check_eq("rst_mid_p10_kept", d, pat6);
        host_read(2'd2, 0, d);
        check_eq("rst_mid_p0_cleared", d, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
